aes_cipher_var: RTL
===================

# aes_cipher_var

Iterative AES encryption engine that supports 128-, 192- and 256-bit keys, selectable at runtime. It is the parametrised successor to the fixed AES-128 cipher top. The key is expanded once into an internal round-key store, and each block is then processed at one round per clock. Blocks enter through a valid/ready input and leave through a valid/ready output, so the engine drops into the same datapath slot as the current cipher top.

## Interface
- MAX_KEY_BITS, default 256: largest key size supported (128, 192 or 256); sizes the round-key store at 4*(Nr_max+1) words.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low; clears all state.
- key_ld  in  1  load-key strobe; taken only when key_ready=1.
- key_len  in  2  key size: 0=128, 1=192, 2=256, 3=reserved.
- key  in  256  key, left-justified; for 128-bit keys only [255:128] is used, for 192-bit keys only [255:64].
- key_ready  out  1  engine can accept key_ld (states IDLE and READY).
- key_valid  out  1  round keys are complete and usable.
- key_err  out  1  last key_ld was rejected (key_len=3 or key size > MAX_KEY_BITS); sticky until the next key_ld.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  engine accepts plaintext this cycle.
- text_in  in  128  plaintext.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  downstream accepts ciphertext.
- text_out  out  128  ciphertext.
- busy  out  1  state is KEXP or ROUND.

## Operation
- Nk = 4/6/8 and Nr = 10/12/14 for key_len 0/1/2.
- FSM states:
  - IDLE: no valid key.
  - KEXP: key expansion.
  - READY: key valid, engine free.
  - ROUND: block in flight.
- IDLE or READY, on key_ld:
  - Legal key_len: words w[0..Nk-1] are loaded from key, key_valid clears, key_err clears, state goes to KEXP.
  - Illegal key_len: key_err sets, key_valid clears, state goes to IDLE.
- KEXP generates one word per cycle for i = Nk .. 4(Nr+1)-1:
  - When i mod Nk = 0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk].
  - When Nk=8 and i mod 8 = 4: w[i] = w[i-8] ^ SubWord(w[i-1]).
  - Otherwise: w[i] = w[i-Nk] ^ w[i-1].
  - After the last word the FSM moves to READY and key_valid sets.
- in_ready = 1 only in READY. On an in_valid & in_ready handshake: state register ← text_in ^ rk[0], round counter ← 1, FSM goes to ROUND.
- ROUND:
  - Rounds 1..Nr-1 apply SubBytes, ShiftRows, MixColumns and AddRoundKey(rk[r]).
  - Round Nr omits MixColumns and loads the result into text_out, sets out_valid, and returns the FSM to READY.
  - If round Nr is reached while out_valid=1 and out_ready=0, the engine stalls: state, counter and FSM hold until the output slot frees.
- Output: out_valid clears on out_valid & out_ready. If the final round completes in the same cycle that the old result is drained, the new result is loaded and out_valid stays 1.
- key_ld in KEXP or ROUND is ignored: key_ready=0 and nothing changes.
- in_valid in any state other than READY is ignored; no handshake occurs.
- Reset, including mid-block or mid-expansion:
  - All outputs go to 0: key_ready, key_valid, key_err, in_ready, out_valid, text_out=0, busy.
  - FSM goes to IDLE. In-flight data and the key are discarded; round-key store contents are don't-care.

## Timing
- key_ld accepted at edge k: key_valid and in_ready are 1 after edge k + 4(Nr+1) - Nk, i.e. 40/46/52 cycles for 128/192/256.
- Block accepted at edge t: out_valid is 1 after edge t+Nr (10/12/14) when there is no stall.
- in_ready returns in the cycle after the final round, giving a peak throughput of one block per Nr+1 cycles.
- key_ready = 1 in the cycle after the reset deassertion edge.
- All outputs are registered or derived only from FSM state; there is no combinational path from in_valid or out_ready to any output.

## Structure
- Shared package aes_pkg holds:
  - key_len_t enum.
  - NK/NR lookup functions.
  - Rcon table (10 entries).
  - Shared xtime/mix_col functions.
  - FSM state enum.
- Sub-module aes_key_sched_var contains the KEXP counter, a word store of 60×32 maximum with a 4-word read port indexed by round, four aes_sbox for SubWord, and the Rcon index.
- The top contains the FSM, round counter, 16 aes_sbox datapath instances, and the output register.

## Test plan
- FIPS-197 C.1: key_len=0, key 000102…0f, text_in 00112233445566778899aabbccddeeff → text_out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 cycles after accept, key_valid 40 cycles after key_ld.
- FIPS-197 C.2 and C.3: key_len=1 with key 000102…17 → dda97ca4864cdfe06eaf70a0ec0d7191; key_len=2 with key 000102…1f → 8ea2b7ca516745bfeafc49904b496089; latencies 12/46 and 14/52.
- Back-pressure: hold out_ready=0 while submitting two C.1 blocks → second block stalls at round 10; releasing out_ready yields both results in order, unchanged.
- Illegal key: key_len=3 → key_err=1, key_valid=0, in_ready=0. With MAX_KEY_BITS=128, key_len=2 → key_err=1.
- Ignored inputs: key_ld pulse during ROUND and in_valid during KEXP → no state change, C.1 result unaffected.
- Reset mid-op: assert rst low during round 5 → all outputs 0 immediately. After release, key_valid=0 until a new key_ld, and a re-run of C.1 is correct.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, round constants and GF(2^8) helpers.
package aes_pkg;
  typedef enum logic [1:0] {KL_128, KL_192, KL_256, KL_RSV} key_len_t;
  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_READY, S_ROUND} state_t;
  localparam logic [79:0] RCON = 80'h01020408102040801b36;
  function automatic logic [3:0] nk(key_len_t k);
    return 4'd4 + {1'b0, k, 1'b0};
  endfunction
  function automatic logic [3:0] nr(key_len_t k);
    return 4'd10 + {1'b0, k, 1'b0};
  endfunction
  function automatic logic [7:0] rcon(logic [3:0] i);
    return RCON[8*(10-int'(i)) +: 8];
  endfunction
  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // Inverse as a^254 by square-and-multiply, then the FIPS-197 affine map.
  function automatic logic [7:0] sbox_f(logic [7:0] a);
    logic [7:0] x2, x3, x12, t, v;
    x2  = gmul(a, a);
    x3  = gmul(x2, a);
    x12 = gmul(gmul(x3, x3), gmul(x3, x3));
    t   = gmul(x12, x3);
    t   = gmul(t, t);
    t   = gmul(t, t);
    t   = gmul(t, t);
    t   = gmul(t, t);
    v   = gmul(gmul(t, x12), x2);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] mix_col(logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction
endpackage

// File: rtl/aes_key_sched_var.sv
// aes_key_sched_var: one-word-per-cycle key expansion into a round-key store with a 4-word round read port.
module aes_key_sched_var
  import aes_pkg::*;
#(
  parameter int WORDS = 60
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  key_len_t       i_key_len,
  input  logic [255:0]   i_key,
  input  logic [3:0]     i_round,
  output logic           o_done,
  output logic [127:0]   o_rk
);
  logic [31:0] r_w [WORDS];
  logic [5:0]  r_i, r_last;
  logic [3:0]  r_nk, r_j, r_rc;
  logic        r_act;
  logic [31:0] w_prev, w_sin, w_sub, w_new;
  assign w_prev = r_w[r_i - 6'd1];
  assign w_sin  = r_j == 4'd0 ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  for (genvar i = 0; i < 4; i++) begin : g_sb
    aes_sbox u_sb (.i_a(w_sin[8*i +: 8]), .o_s(w_sub[8*i +: 8]));
  end
  // r_j tracks i mod Nk and r_rc tracks i/Nk so no divider is needed.
  assign w_new  = r_w[r_i - {2'b00, r_nk}] ^ (r_j == 4'd0 ? w_sub ^ {rcon(r_rc), 24'h0}
                : (r_nk == 4'd8 && r_j == 4'd4) ? w_sub : w_prev);
  assign o_done = r_act && r_i == r_last;
  assign o_rk   = {r_w[{i_round, 2'd0}], r_w[{i_round, 2'd1}], r_w[{i_round, 2'd2}], r_w[{i_round, 2'd3}]};
  always_ff @(posedge clk) begin
    if (i_load)
      for (int k = 0; k < 8; k++) r_w[k] <= i_key[255-32*k -: 32];
    else if (r_act)
      r_w[r_i] <= w_new;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_act  <= 1'b0;
      r_i    <= '0;
      r_last <= '0;
      r_nk   <= 4'd4;
      r_j    <= '0;
      r_rc   <= 4'd1;
    end else if (i_load) begin
      r_act  <= 1'b1;
      r_nk   <= nk(i_key_len);
      r_i    <= {2'b00, nk(i_key_len)};
      r_last <= {nr(i_key_len), 2'b11};
      r_j    <= '0;
      r_rc   <= 4'd1;
    end else if (r_act) begin
      r_act  <= !o_done;
      r_i    <= r_i + 6'd1;
      r_j    <= r_j == r_nk - 4'd1 ? 4'd0 : r_j + 4'd1;
      r_rc   <= r_rc + {3'b000, r_j == r_nk - 4'd1};
    end
  end
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  assign o_s = sbox_f(i_a);
endmodule

// File: rtl/aes_cipher_var.sv
// aes_cipher_var: iterative AES-128/192/256 encryptor, one round per clock,
// valid/ready block interfaces and a runtime key load.
module aes_cipher_var
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_ld,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         key_ready,
  output logic         key_valid,
  output logic         key_err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] text_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] text_out,
  output logic         busy
);
  localparam int WORDS = 4 * (MAX_KEY_BITS / 32 + 7);
  state_t       r_state, w_next;
  logic [127:0] r_st, r_out, w_rk, w_sb, w_sr, w_mc, w_nx;
  logic [3:0]   r_rnd, r_nr;
  logic         r_kv, r_kerr, r_ov;
  logic         w_kld, w_legal, w_done, w_acc, w_last, w_stall, w_fin;
  assign w_kld   = key_ld && key_ready;
  assign w_legal = (key_len != 2'd3) && ((128 + 64 * int'(key_len)) <= MAX_KEY_BITS);
  assign w_acc   = in_valid && in_ready && !w_kld;
  assign w_last  = r_rnd == r_nr;
  assign w_stall = w_last && r_ov && !out_ready;
  assign w_fin   = r_state == S_ROUND && w_last && !w_stall;
  aes_key_sched_var #(.WORDS(WORDS)) u_ks (
    .clk(clk), .rst(rst), .i_load(w_kld && w_legal), .i_key_len(key_len_t'(key_len)),
    .i_key(key), .i_round(r_state == S_ROUND ? r_rnd : 4'd0), .o_done(w_done), .o_rk(w_rk)
  );
  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sb (.i_a(r_st[8*i +: 8]), .o_s(w_sb[8*i +: 8]));
  end
  for (genvar i = 0; i < 4; i++) begin : g_col
    for (genvar j = 0; j < 4; j++) begin : g_row
      assign w_sr[127-32*i-8*j -: 8] = w_sb[127-32*((i+j)%4)-8*j -: 8];
    end
    assign w_mc[127-32*i -: 32] = mix_col(w_sr[127-32*i -: 32]);
  end
  assign w_nx = (w_last ? w_sr : w_mc) ^ w_rk;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end
  always_comb begin
    w_next    = w_kld ? (w_legal ? S_KEXP : S_IDLE)
              : ((r_state == S_KEXP && w_done) || w_fin) ? S_READY
              : w_acc ? S_ROUND : r_state;
    key_ready = rst && (r_state == S_IDLE || r_state == S_READY);
    in_ready  = r_state == S_READY;
    busy      = r_state == S_KEXP || r_state == S_ROUND;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kv   <= 1'b0;
      r_kerr <= 1'b0;
      r_ov   <= 1'b0;
      r_nr   <= 4'd10;
      r_rnd  <= '0;
      r_st   <= '0;
      r_out  <= '0;
    end else begin
      if (w_kld) begin
        r_kv   <= 1'b0;
        r_kerr <= !w_legal;
      end else if (r_state == S_KEXP && w_done) r_kv <= 1'b1;
      if (w_kld && w_legal) r_nr <= nr(key_len_t'(key_len));
      if (w_acc) begin
        r_st  <= text_in ^ w_rk;
        r_rnd <= 4'd1;
      end else if (r_state == S_ROUND && !w_last) begin
        r_st  <= w_nx;
        r_rnd <= r_rnd + 4'd1;
      end
      // A final round finishing while the old result drains keeps out_valid high.
      if (w_fin) begin
        r_out <= w_nx;
        r_ov  <= 1'b1;
      end else if (out_ready) r_ov <= 1'b0;
    end
  end
  assign key_valid = r_kv;
  assign key_err   = r_kerr;
  assign out_valid = r_ov;
  assign text_out  = r_out;
endmodule
